// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART blocks: board clock and baud constants
//   (also used by uart_rx / uart_tx instantiations), the transmit-queue state
//   encoding and its acknowledge guard timeout.
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int CLK_FREQ = 12_000_000;
    localparam int BAUD     = 9_600;

    // Cycles the transmit queue waits for tx_busy to rise before giving up.
    localparam int TXQ_ACK_TIMEOUT = 4;
    localparam int TXQ_GUARD_W     = $clog2(TXQ_ACK_TIMEOUT);

    typedef enum logic [1:0] {
        TXQ_IDLE,
        TXQ_START,
        TXQ_WAIT_ACK,
        TXQ_WAIT_DONE
    } txq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with show-ahead read: rd_data always presents the head
//   entry, rd_en consumes it. Occupancy is tracked by an explicit counter so
//   full/empty never depend on pointer equality.
//
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   wr_en    in   enqueue wr_data (ignored while full)
//   wr_data  in   WIDTH-bit entry
//   rd_en    in   dequeue the head (ignored while empty)
//   rd_data  out  head entry, valid while !empty
//   full     out  FIFO holds DEPTH entries
//   empty    out  FIFO holds no entries
//   count    out  occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter  int DEPTH  = 16,
    parameter  int WIDTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              do_wr, do_rd;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign count = count_q;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // NOTE: every signal assigned in an always_comb block gets a default at
    // the top, so no path can leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are exactly ADDR_W bits wide, so the increment wraps mod DEPTH.
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (!do_wr && do_rd) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; entries are only
    // observable once written, and leaving it reset-free lets it map to RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_tx_queue.sv
// ----------------------------------------------------------------------------
// uart_tx_queue
//   Transmit front end for uart_tx. Producers write bytes into a sync_fifo; a
//   small FSM pops one byte at a time and runs the tx_start / tx_busy
//   handshake with uart_tx.
//
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   wr_en     in   producer write strobe, one byte per cycle
//   wr_data   in   byte to enqueue
//   full      out  FIFO holds DEPTH bytes (combinational)
//   empty     out  FIFO holds no bytes (combinational)
//   count     out  FIFO occupancy, 0..DEPTH
//   overflow  out  sticky: a write was dropped because the FIFO was full
//   idle      out  queue empty, FSM idle and uart_tx not busy (combinational)
//   tx_start  out  one-cycle start pulse to uart_tx
//   tx_data   out  byte for uart_tx, held until the next pop
//   tx_busy   in   uart_tx is shifting a frame out
// ----------------------------------------------------------------------------
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              idle,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy
);

    localparam logic [TXQ_GUARD_W-1:0] GUARD_LAST = TXQ_GUARD_W'(TXQ_ACK_TIMEOUT - 1);

    txq_state_t             state_q,    state_d;
    logic                   tx_start_q, tx_start_d;
    logic [7:0]             tx_data_q,  tx_data_d;
    logic [TXQ_GUARD_W-1:0] guard_q,    guard_d;
    logic                   overflow_q, overflow_d;
    logic                   pop;
    logic [7:0]             head;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        guard_d    = guard_q;
        pop        = 1'b0;
        // full is the pre-edge value, so a write while full is lost even if a
        // pop frees a slot on the same edge.
        overflow_d = overflow_q | (wr_en & full);

        case (state_q)
            TXQ_IDLE: begin
                // Waiting for !tx_busy also covers a reset taken mid-frame:
                // uart_tx finishes that frame before we start another.
                if (!empty && !tx_busy) begin
                    state_d    = TXQ_START;
                    tx_start_d = 1'b1;
                    tx_data_d  = head;
                    pop        = 1'b1;
                end
            end
            TXQ_START: begin
                state_d = TXQ_WAIT_ACK;
                guard_d = '0;
            end
            TXQ_WAIT_ACK: begin
                // A uart_tx that never raises busy (or finishes instantly)
                // must not hang the queue.
                if (tx_busy) begin
                    state_d = TXQ_WAIT_DONE;
                end else if (guard_q == GUARD_LAST) begin
                    state_d = TXQ_IDLE;
                end else begin
                    guard_d = guard_q + 1'b1;
                end
            end
            TXQ_WAIT_DONE: begin
                if (!tx_busy) state_d = TXQ_IDLE;
            end
            default: state_d = TXQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TXQ_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            guard_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            guard_q    <= guard_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;
    assign idle     = empty && (state_q == TXQ_IDLE) && !tx_busy;

endmodule
